bitstream_modulator: RTL
========================

Name: bitstream_modulator

Overview:
- Transmit-side counterpart of the team's 1-bit decimating filter.
- Accepts 8-bit samples through a valid/ready handshake and holds each one for OSR clock cycles.
- Emits a first-order sigma-delta 1-bit stream whose ones-density over a frame equals sample/256.
- Drives the filter's serial IN directly. One sample in becomes one OSR-cycle frame out.

Parameters:
- OSR, 64, clock cycles per sample frame; power of two, 4..256.
- DW, 8, sample width.

Ports:
- CLK  input  1  clock
- RST  input  1  reset, asynchronous, active-low
- IN_DATA  input  DW  unsigned sample
- IN_VALID  input  1  sample offered
- IN_READY  output  1  FIFO can accept a sample
- ENABLE  input  1  run request
- OUT  output  1  modulated bitstream, registered
- FRAME  output  1  high with the first OUT bit of each frame
- BUSY  output  1  FSM in RUN
- UNDERRUN  output  1  one-cycle pulse when a frame repeats for lack of data
- UNDER_CNT  output  8  saturating underrun count

Behaviour:
- Reset (RST low, async) clears:
  - all outputs to 0;
  - FIFO empty; IN_READY = 1 after reset release;
  - acc, cur, cnt = 0; FSM = IDLE.
- Input FIFO:
  - 2 entries, DW wide.
  - Push when IN_VALID & IN_READY at the clock edge.
  - IN_READY = (fill < 2), derived from registered fill.
  - Push and pop in the same cycle leave fill unchanged.
  - Data is never dropped or duplicated by the FIFO.
- FSM:
  - IDLE:
    - OUT = 0, FRAME = 0, cnt held at 0, acc held.
    - If ENABLE & FIFO non-empty: pop into cur, cnt <= 0, go to RUN.
  - RUN, every cycle:
    - sum = {1'b0, acc} + {1'b0, cur} (DW+1 bits).
    - acc <= sum[DW-1:0]; OUT <= sum[DW].
    - FRAME <= (cnt == 0); cnt <= cnt + 1 mod OSR.
  - RUN, at cnt == OSR-1 (frame end):
    - ENABLE = 0: go to IDLE. No pop. acc is retained.
    - ENABLE = 1, FIFO non-empty: pop into cur; the next frame uses the new sample.
    - ENABLE = 1, FIFO empty: keep cur (repeat the frame), pulse UNDERRUN, UNDER_CNT += 1, saturating at 255.
  - ENABLE deasserted mid-frame does not truncate the frame; it is sampled only at frame end.
- Latency:
  - Push at edge T with FSM in IDLE and ENABLE high: IDLE pops at edge T+1.
  - First RUN computation occurs in the cycle after edge T+1.
  - OUT and FRAME show the first bit after edge T+2.
  - Every frame is exactly OSR consecutive OUT bits, and FRAME is high on the first of them.
- Density:
  - Ones in a frame = floor((acc_start + OSR*cur) / 256), where acc_start is acc at frame start.
  - Sample 0 gives all zeros. Sample 255 with acc_start = 0 gives OSR-1 ones.
- Accumulator continuity: acc is continuous across frames and IDLE periods; it is cleared only by RST.
- BUSY = 1 exactly while the FSM is in RUN.
- Reset mid-frame: returns to the reset state immediately. The partial frame is abandoned and the FIFO contents are discarded.

Test Plan:
- Reset then idle: RST low for 3 cycles, then released, ENABLE = 1, no samples offered. Required: OUT = 0, BUSY = 0, IN_READY = 1, UNDER_CNT = 0 indefinitely.
- Mid-scale pattern: after reset, push 128. Required:
  - OUT pattern 0,1,0,1,... for 64 bits with FRAME on bit 1 of the frame;
  - 32 ones in the frame;
  - first bit appears 2 cycles after the push edge.
- Extremes:
  - Push 0 then 255 back to back, starting from acc = 0. Required: frame 1 has 0 ones; frame 2 has 63 ones; the two frames are contiguous with no gap.
  - With the filter wired downstream, its output settles accordingly.
- Backpressure: hold IN_VALID high with samples 10, 20, 30, 40. Required:
  - IN_READY drops after 2 entries (one more can sit in cur);
  - samples emerge in order, one per frame;
  - no loss, verified by ones-count per frame.
- Underrun: push only 200, ENABLE high. Required:
  - at the end of frame 1, UNDERRUN pulses for 1 cycle and UNDER_CNT = 1;
  - frame 2 repeats 200, so ones = floor((acc_start + 12800)/256);
  - after 300 frames, UNDER_CNT = 255 (saturated).
- ENABLE drop and reset mid-frame:
  - Deassert ENABLE at cnt = 10. Required: the frame completes all 64 bits, then IDLE with BUSY = 0.
  - Assert RST at cnt = 30 of a later frame. Required: OUT, FRAME, BUSY = 0 immediately (async); FIFO empty.

Source files
------------

// File: rtl/bitstream_modulator.sv
// First-order sigma-delta bitstream modulator.
// Samples enter a two-entry FIFO through a valid/ready handshake. Each sample
// is held for one OSR-cycle frame while a DW-bit accumulator integrates it.
// The carry out of the accumulator is the output bit, so the ones-density of
// a frame tracks sample/2^DW. The carry feeds the 1-bit decimating filter's
// serial input directly.
module bitstream_modulator #(
    parameter int OSR = 64,
    parameter int DW  = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] IN_DATA,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic          ENABLE,
    output logic          OUT,
    output logic          FRAME,
    output logic          BUSY,
    output logic          UNDERRUN,
    output logic [7:0]    UNDER_CNT
);
    localparam int CW = $clog2(OSR);
    localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] fifo0_q, fifo0_d;
    logic [DW-1:0] fifo1_q, fifo1_d;
    logic [1:0]    fill_q, fill_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] cur_q, cur_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          frame_q, frame_d;
    logic          underrun_q, underrun_d;
    logic [7:0]    under_cnt_q, under_cnt_d;
    logic          push;
    logic          pop;
    logic [DW:0]   sum;

    // Ready comes straight from the registered fill level so it never depends
    // on this cycle's pop.
    assign IN_READY  = (fill_q != 2'd2);
    assign push      = IN_VALID && IN_READY;

    assign OUT       = out_q;
    assign FRAME     = frame_q;
    assign BUSY      = (state_q == RUN);
    assign UNDERRUN  = underrun_q;
    assign UNDER_CNT = under_cnt_q;

    // Frame sequencer: integrate cur into acc, count frame cycles, and at a
    // frame boundary choose between stopping, loading the next sample, or
    // repeating the current one.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        out_d       = 1'b0;
        frame_d     = 1'b0;
        underrun_d  = 1'b0;
        under_cnt_d = under_cnt_q;
        pop         = 1'b0;
        sum         = {1'b0, acc_q} + {1'b0, cur_q};
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ENABLE && (fill_q != 2'd0)) begin
                    pop     = 1'b1;
                    cur_d   = fifo0_q;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = sum[DW-1:0];
                out_d   = sum[DW];
                frame_d = (cnt_q == '0);
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    if (!ENABLE) begin
                        state_d = IDLE;
                    end else if (fill_q != 2'd0) begin
                        pop   = 1'b1;
                        cur_d = fifo0_q;
                    end else begin
                        underrun_d = 1'b1;
                        if (under_cnt_q != 8'hFF) begin
                            under_cnt_d = under_cnt_q + 8'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-entry shift FIFO: slot 0 is always the head; a push lands in the
    // first slot that is free once this cycle's pop is accounted for.
    always_comb begin
        fifo0_d = fifo0_q;
        fifo1_d = fifo1_q;
        fill_d  = fill_q;
        if (pop) begin
            fifo0_d = fifo1_q;
        end
        if (push) begin
            if ((fill_q == 2'd0) || ((fill_q == 2'd1) && pop)) begin
                fifo0_d = IN_DATA;
            end else begin
                fifo1_d = IN_DATA;
            end
        end
        if (push && !pop) begin
            fill_d = fill_q + 2'd1;
        end else if (pop && !push) begin
            fill_d = fill_q - 2'd1;
        end
    end

    // Control, accumulator and output registers; async reset abandons any
    // partial frame and empties the FIFO.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            fill_q      <= 2'd0;
            acc_q       <= '0;
            cur_q       <= '0;
            cnt_q       <= '0;
            out_q       <= 1'b0;
            frame_q     <= 1'b0;
            underrun_q  <= 1'b0;
            under_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            acc_q       <= acc_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            frame_q     <= frame_d;
            underrun_q  <= underrun_d;
            under_cnt_q <= under_cnt_d;
        end
    end

    // FIFO storage needs no reset: the fill level alone decides validity.
    always_ff @(posedge CLK) begin
        fifo0_q <= fifo0_d;
        fifo1_q <= fifo1_d;
    end

endmodule
